fp_mant_align_seq: RTL and testbench

- Sequential mantissa alignment unit for the FP adder datapath. It is the pre-add counterpart to the post-add normalizing shifter.
- Right-shifts the smaller operand's 25-bit mantissa by the exponent difference, one bit per clock.
- Raises its exponent by the same amount and collects guard/round/sticky bits for the rounding stage.
- Sits between exponent compare and the mantissa adder; uses a start/done handshake.

---
 rtl/fp_mant_align_seq.sv | 111 +++++++++++
 tb/tb_fp_mant_align_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fp_mant_align_seq.sv
// Sequential mantissa aligner for the FP adder: shifts the smaller operand right
// one bit per clock, bumps its exponent, and collects guard/round/sticky bits.
module fp_mant_align_seq #(
    parameter int MANT_W    = 25,
    parameter int EXP_W     = 8,
    parameter int MAX_SHIFT = MANT_W + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [EXP_W-1:0]  shift_amt,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              guard,
    output logic              round,
    output logic              sticky,
    output logic              exp_ovf,
    output logic [1:0]        state_dbg
);

    // Handshake: start is sampled only in IDLE; done pulses for one cycle in
    // DONE and busy covers SHIFT and DONE, so start is ignored while busy.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] MAX_SHIFT_V = EXP_W'(MAX_SHIFT);

    state_t           state;
    state_t           state_next;
    logic [EXP_W-1:0] cnt;
    logic [EXP_W:0]   exp_sum;
    logic             accept;
    logic             fast_path;
    logic             zero_shift;

    assign exp_sum    = {1'b0, exp_in} + {1'b0, shift_amt};
    assign accept     = (state == IDLE) && start;
    assign fast_path  = (shift_amt >= MAX_SHIFT_V);
    assign zero_shift = (shift_amt == '0);

    assign busy      = (state == SHIFT) || (state == DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (zero_shift || fast_path) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == EXP_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mant_out <= '0;
            exp_out  <= '0;
            guard    <= 1'b0;
            round    <= 1'b0;
            sticky   <= 1'b0;
            exp_ovf  <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            exp_ovf <= exp_sum[EXP_W];
            exp_out <= exp_sum[EXP_W] ? '1 : exp_sum[EXP_W-1:0];
            guard   <= 1'b0;
            round   <= 1'b0;
            // Shifts this large leave nothing in mant/guard/round; only sticky survives.
            if (fast_path) begin
                mant_out <= '0;
                sticky   <= |mant_in;
                cnt      <= '0;
            end else begin
                mant_out <= mant_in;
                sticky   <= 1'b0;
                cnt      <= shift_amt;
            end
        end else if (state == SHIFT) begin
            mant_out <= mant_out >> 1;
            guard    <= mant_out[0];
            round    <= guard;
            sticky   <= sticky | round;
            cnt      <= cnt - EXP_W'(1);
        end
    end

endmodule

// File: tb/tb_fp_mant_align_seq.sv
// Directed bench for fp_mant_align_seq: hand-computed alignment results,
// latency, handshake corner cases and reset abort.
module tb_fp_mant_align_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [24:0] mant_in;
    logic [7:0]  exp_in;
    logic [7:0]  shift_amt;
    logic        busy;
    logic        done;
    logic [24:0] mant_out;
    logic [7:0]  exp_out;
    logic        guard;
    logic        round;
    logic        sticky;
    logic        exp_ovf;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    fp_mant_align_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .shift_amt (shift_amt),
        .busy      (busy),
        .done      (done),
        .mant_out  (mant_out),
        .exp_out   (exp_out),
        .guard     (guard),
        .round     (round),
        .sticky    (sticky),
        .exp_ovf   (exp_ovf),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge one cycle
    // after done, which is the earliest cycle a new start can be accepted.
    task automatic run_op(input string tag, input logic [24:0] m, input logic [7:0] e,
                          input logic [7:0] s, input logic poke, input int exp_lat,
                          input logic [24:0] exp_m, input logic [7:0] exp_e,
                          input logic exp_g, input logic exp_r, input logic exp_s,
                          input logic exp_o);
        int lat;
        mant_in   = m;
        exp_in    = e;
        shift_amt = s;
        start     = 1'b1;
        @(negedge clk);
        lat = 1;
        // Inputs change after acceptance; with poke, start stays high while busy.
        start     = poke;
        mant_in   = 25'($urandom);
        exp_in    = 8'($urandom);
        shift_amt = 8'($urandom_range(1, 40));
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_in_done"}, busy, 1'b1);
        check({tag, ".mant_out"}, mant_out, exp_m);
        check({tag, ".exp_out"}, exp_out, exp_e);
        check({tag, ".grs"}, {guard, round, sticky}, {exp_g, exp_r, exp_s});
        check({tag, ".exp_ovf"}, exp_ovf, exp_o);
        @(negedge clk);
        start = 1'b0;
        check({tag, ".done_pulse"}, {done, busy}, 2'b00);
        check({tag, ".hold"}, {mant_out, exp_out}, {exp_m, exp_e});
    endtask

    initial begin
        bit seen_done;
        reset     = 1'b1;
        start     = 1'b0;
        mant_in   = '0;
        exp_in    = '0;
        shift_amt = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.ctrl", {busy, done, state_dbg}, 4'b0000);
        check("reset.mant", mant_out, 25'h0);
        check("reset.exp", {exp_out, exp_ovf}, 9'h0);
        check("reset.grs", {guard, round, sticky}, 3'b000);

        run_op("sh3",    25'h1000001, 8'd10,  8'd3,   1'b0, 4,  25'h0200000, 8'd13,  1'b0, 1'b0, 1'b1, 1'b0);
        run_op("ovf",    25'h0000007, 8'd254, 8'd2,   1'b0, 3,  25'h0000001, 8'hFF,  1'b1, 1'b1, 1'b0, 1'b1);
        run_op("sh0",    25'h1ABCDEF, 8'd5,   8'd0,   1'b0, 1,  25'h1ABCDEF, 8'd5,   1'b0, 1'b0, 1'b0, 1'b0);
        run_op("fast40", 25'h0000010, 8'd20,  8'd40,  1'b0, 1,  25'h0000000, 8'd60,  1'b0, 1'b0, 1'b1, 1'b0);
        run_op("sh26",   25'h1000000, 8'd100, 8'd26,  1'b0, 27, 25'h0000000, 8'd126, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("fast27", 25'h1000000, 8'd100, 8'd27,  1'b0, 1,  25'h0000000, 8'd127, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("poke",   25'h1FFFFFF, 8'd200, 8'd5,   1'b1, 6,  25'h00FFFFF, 8'd205, 1'b1, 1'b1, 1'b1, 1'b0);
        run_op("exp255", 25'h0000020, 8'd250, 8'd5,   1'b0, 6,  25'h0000001, 8'hFF,  1'b0, 1'b0, 1'b0, 1'b0);
        run_op("fastof", 25'h1FFFFFF, 8'd1,   8'd255, 1'b0, 1,  25'h0000000, 8'hFF,  1'b0, 1'b0, 1'b1, 1'b1);

        // Reset four cycles into a 10-bit shift must abort with no done pulse.
        mant_in   = 25'h1FFFFFF;
        exp_in    = 8'd3;
        shift_amt = 8'd10;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.ctrl", {busy, done, state_dbg}, 4'b0000);
        check("abort.data", {mant_out, exp_out, exp_ovf}, 34'h0);
        check("abort.grs", {guard, round, sticky}, 3'b000);
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort.no_done", seen_done, 1'b0);

        run_op("after",  25'h0000003, 8'd7,   8'd1,   1'b0, 2,  25'h0000001, 8'd8,   1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
